// File: rtl/act_row_feeder_if.sv
// Controller-side bundle of the activation row feeder: tagged source stream,
// flush, per-row activation ports and status.
interface act_row_feeder_if #(
  parameter int N_ROW   = 3,
  parameter int WID_ACT = 16,
  parameter int WID_ROW = 2,
  parameter int WID_CNT = 16
);
  logic [2*WID_ACT-1:0]       src_data;
  logic [WID_ROW-1:0]         src_row;
  logic                       src_vld;
  logic                       src_rdy;
  logic                       flush;
  logic [2*WID_ACT*N_ROW-1:0] act_data_in;
  logic [N_ROW-1:0]           act_data_in_vld;
  logic [N_ROW-1:0]           act_data_in_req;
  logic [WID_CNT*N_ROW-1:0]   xfer_cnt;
  logic [N_ROW-1:0]           fifo_empty;
  logic                       err_row;

  modport master (
    output src_data, src_row, src_vld, flush, act_data_in_req,
    input  src_rdy, act_data_in, act_data_in_vld, xfer_cnt, fifo_empty, err_row
  );

  modport slave (
    input  src_data, src_row, src_vld, flush, act_data_in_req,
    output src_rdy, act_data_in, act_data_in_vld, xfer_cnt, fifo_empty, err_row
  );
endinterface

// File: rtl/act_row_feeder.sv
// Steers a tagged activation-word stream into one FIFO per superblock row and
// drives each row's act_data_in port; supports broadcast, flush and bad-tag flag.
module act_row_feeder #(
  parameter int N_ROW      = 3,
  parameter int WID_ACT    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int WID_ROW    = 2,
  parameter int WID_CNT    = 16
) (
  input logic             clk_l,
  input logic             rst,
  act_row_feeder_if.slave bus
);
  localparam int WORD_W = 2 * WID_ACT;
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam logic [WID_ROW-1:0] BCAST     = {WID_ROW{1'b1}};
  localparam logic [WID_ROW-1:0] ROW_LIMIT = WID_ROW'(N_ROW);

  logic [WORD_W-1:0]  mem_q    [N_ROW][FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q [N_ROW];
  logic [PTR_W-1:0]   wr_ptr_d [N_ROW];
  logic [PTR_W-1:0]   rd_ptr_q [N_ROW];
  logic [PTR_W-1:0]   rd_ptr_d [N_ROW];
  logic [WID_CNT-1:0] cnt_q    [N_ROW];
  logic [WID_CNT-1:0] cnt_d    [N_ROW];
  logic               err_q;
  logic               err_d;

  logic [N_ROW-1:0] full;
  logic [N_ROW-1:0] empty;
  logic [N_ROW-1:0] row_sel;
  logic [N_ROW-1:0] push;
  logic [N_ROW-1:0] pop;
  logic             is_bcast;
  logic             is_valid;
  logic             rdy;
  logic             accept;

  // Pointers carry a wrap bit: equal -> empty, only the wrap bit differs -> full.
  always_comb begin
    full  = '0;
    empty = '0;
    for (int r = 0; r < N_ROW; r++) begin
      empty[r] = (wr_ptr_q[r] == rd_ptr_q[r]);
      full[r]  = (wr_ptr_q[r][PTR_W-1] != rd_ptr_q[r][PTR_W-1]) &&
                 (wr_ptr_q[r][ADDR_W-1:0] == rd_ptr_q[r][ADDR_W-1:0]);
    end
  end

  // Handshake: a source word moves when src_vld & src_rdy at a clock edge; a
  // row word moves when act_data_in_vld[r] & act_data_in_req[r]. src_rdy is a
  // function of src_row and FIFO occupancy only and never looks at src_vld.
  always_comb begin
    is_bcast = (bus.src_row == BCAST);
    is_valid = (bus.src_row < ROW_LIMIT);
    row_sel  = '0;
    for (int r = 0; r < N_ROW; r++) begin
      row_sel[r] = is_bcast | (bus.src_row == WID_ROW'(r));
    end

    if (rst || bus.flush) begin
      rdy = 1'b0;
    end else if (is_bcast) begin
      rdy = ~|full;
    end else if (is_valid) begin
      rdy = ~|(row_sel & full);
    end else begin
      rdy = 1'b1;
    end

    accept = bus.src_vld & rdy;
    push   = accept ? row_sel : '0;
    pop    = bus.flush ? '0 : (~empty & bus.act_data_in_req);
  end

  always_comb begin
    err_d = err_q | (accept & ~is_bcast & ~is_valid);
    for (int r = 0; r < N_ROW; r++) begin
      wr_ptr_d[r] = wr_ptr_q[r] + PTR_W'(push[r]);
      rd_ptr_d[r] = rd_ptr_q[r] + PTR_W'(pop[r]);
      cnt_d[r]    = cnt_q[r] + WID_CNT'(pop[r]);
      if (bus.flush) begin
        wr_ptr_d[r] = '0;
        rd_ptr_d[r] = '0;
        cnt_d[r]    = '0;
      end
    end
  end

  always_ff @(posedge clk_l or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
      for (int r = 0; r < N_ROW; r++) begin
        wr_ptr_q[r] <= '0;
        rd_ptr_q[r] <= '0;
        cnt_q[r]    <= '0;
      end
    end else begin
      err_q <= err_d;
      for (int r = 0; r < N_ROW; r++) begin
        wr_ptr_q[r] <= wr_ptr_d[r];
        rd_ptr_q[r] <= rd_ptr_d[r];
        cnt_q[r]    <= cnt_d[r];
      end
    end
  end

  // Storage needs no reset: the output slice is forced to zero while empty.
  always_ff @(posedge clk_l) begin
    for (int r = 0; r < N_ROW; r++) begin
      if (push[r]) begin
        mem_q[r][wr_ptr_q[r][ADDR_W-1:0]] <= bus.src_data;
      end
    end
  end

  always_comb begin
    bus.act_data_in     = '0;
    bus.act_data_in_vld = ~empty;
    bus.xfer_cnt        = '0;
    bus.fifo_empty      = empty;
    bus.src_rdy         = rdy;
    bus.err_row         = err_q;
    for (int r = 0; r < N_ROW; r++) begin
      bus.act_data_in[r*WORD_W +: WORD_W] =
        empty[r] ? '0 : mem_q[r][rd_ptr_q[r][ADDR_W-1:0]];
      bus.xfer_cnt[r*WID_CNT +: WID_CNT] = cnt_q[r];
    end
  end
endmodule

// File: tb/tb_act_row_feeder.sv
// Directed bench for act_row_feeder: a 3-row instance for the main scenarios
// and a 2-row instance so an out-of-range row tag exists.
module tb_act_row_feeder;
  logic clk_l;
  logic rst;
  int   checks;
  int   failures;

  act_row_feeder_if #(.N_ROW(3), .WID_ACT(16), .WID_ROW(2), .WID_CNT(16)) bus ();
  act_row_feeder_if #(.N_ROW(2), .WID_ACT(16), .WID_ROW(2), .WID_CNT(16)) bus2 ();

  act_row_feeder #(.N_ROW(3), .WID_ACT(16), .FIFO_DEPTH(4), .WID_ROW(2), .WID_CNT(16)) dut (
    .clk_l(clk_l), .rst(rst), .bus(bus)
  );
  act_row_feeder #(.N_ROW(2), .WID_ACT(16), .FIFO_DEPTH(4), .WID_ROW(2), .WID_CNT(16)) dut2 (
    .clk_l(clk_l), .rst(rst), .bus(bus2)
  );

  // clock / reset
  initial clk_l = 1'b0;
  always #5 clk_l = ~clk_l;

  wire [31:0] head0 = bus.act_data_in[31:0];
  wire [31:0] head1 = bus.act_data_in[63:32];
  wire [31:0] head2 = bus.act_data_in[95:64];
  wire [15:0] cnt0  = bus.xfer_cnt[15:0];
  wire [15:0] cnt1  = bus.xfer_cnt[31:16];
  wire [15:0] cnt2  = bus.xfer_cnt[47:32];

  task automatic tick();
    @(posedge clk_l);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.act_data_in_vld !== 3'b000) begin failures++; $display("FAIL rst_vld act=%b exp=000", bus.act_data_in_vld); end
    checks++; if (bus.fifo_empty !== 3'b111) begin failures++; $display("FAIL rst_empty act=%b exp=111", bus.fifo_empty); end
    checks++; if (bus.xfer_cnt !== 48'h0) begin failures++; $display("FAIL rst_cnt act=%h exp=0", bus.xfer_cnt); end
    checks++; if (bus.act_data_in !== 96'h0) begin failures++; $display("FAIL rst_data act=%h exp=0", bus.act_data_in); end
    checks++; if (bus.src_rdy !== 1'b0) begin failures++; $display("FAIL rst_rdy act=%b exp=0", bus.src_rdy); end
    checks++; if ({bus.err_row, bus2.err_row} !== 2'b00) begin failures++; $display("FAIL rst_err act=%b exp=00", {bus.err_row, bus2.err_row}); end
    tick(); tick();
    rst = 1'b0;
    // Partly fill FIFOs and complete one row-2 transfer, then reset mid-stream.
    bus.act_data_in_req = 3'b100;
    bus.src_vld = 1'b1; bus.src_row = 2'd2; bus.src_data = 32'hAAAA_0001;
    tick();
    bus.src_row = 2'd0; bus.src_data = 32'hBBBB_0002;
    tick();
    bus.src_row = 2'd1; bus.src_data = 32'hCCCC_0003;
    tick();
    bus.src_vld = 1'b0;
    checks++; if (cnt2 !== 16'd1) begin failures++; $display("FAIL pre_rst_cnt2 act=%0d exp=1", cnt2); end
    checks++; if (bus.fifo_empty !== 3'b100) begin failures++; $display("FAIL pre_rst_empty act=%b exp=100", bus.fifo_empty); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.act_data_in_vld !== 3'b000) begin failures++; $display("FAIL midrst_vld act=%b exp=000", bus.act_data_in_vld); end
    checks++; if (bus.fifo_empty !== 3'b111) begin failures++; $display("FAIL midrst_empty act=%b exp=111", bus.fifo_empty); end
    checks++; if (bus.xfer_cnt !== 48'h0) begin failures++; $display("FAIL midrst_cnt act=%h exp=0", bus.xfer_cnt); end
    checks++; if (bus.src_rdy !== 1'b0) begin failures++; $display("FAIL midrst_rdy act=%b exp=0", bus.src_rdy); end
    tick();
    rst = 1'b0;
    bus.act_data_in_req = 3'b000;
    #1;
    checks++; if (bus.src_rdy !== 1'b1) begin failures++; $display("FAIL postrst_rdy act=%b exp=1", bus.src_rdy); end
  endtask

  task automatic test_unicast();
    bus.act_data_in_req = 3'b111;
    bus.src_vld = 1'b1; bus.src_row = 2'd1; bus.src_data = 32'h0001_0002;
    tick();
    bus.src_vld = 1'b0;
    checks++; if (bus.act_data_in_vld !== 3'b010) begin failures++; $display("FAIL uni_vld act=%b exp=010", bus.act_data_in_vld); end
    checks++; if (head1 !== 32'h0001_0002) begin failures++; $display("FAIL uni_data act=%h exp=00010002", head1); end
    tick();
    checks++; if (cnt1 !== 16'd1) begin failures++; $display("FAIL uni_cnt1 act=%0d exp=1", cnt1); end
    checks++; if (bus.act_data_in_vld !== 3'b000) begin failures++; $display("FAIL uni_vld_after act=%b exp=000", bus.act_data_in_vld); end
  endtask

  task automatic test_backpressure();
    logic [31:0] w [5];
    logic [31:0] exp_head;
    for (int i = 0; i < 5; i++) w[i] = 32'hD000_0000 + 32'(i);
    bus.act_data_in_req = 3'b000;
    bus.src_vld = 1'b1; bus.src_row = 2'd0;
    for (int i = 0; i < 4; i++) begin
      bus.src_data = w[i];
      #1;
      checks++; if (bus.src_rdy !== 1'b1) begin failures++; $display("FAIL bp_rdy%0d act=%b exp=1", i, bus.src_rdy); end
      tick();
    end
    bus.src_data = w[4];
    #1;
    checks++; if (bus.src_rdy !== 1'b0) begin failures++; $display("FAIL bp_full_rdy act=%b exp=0", bus.src_rdy); end
    checks++; if (head0 !== w[0]) begin failures++; $display("FAIL bp_head_w0 act=%h exp=%h", head0, w[0]); end
    bus.act_data_in_req = 3'b001;
    tick();
    // Full FIFO ignores the same-cycle pop, so w4 goes in one cycle later.
    checks++; if (bus.src_rdy !== 1'b1) begin failures++; $display("FAIL bp_rdy_after_pop act=%b exp=1", bus.src_rdy); end
    for (int i = 1; i < 5; i++) begin
      exp_head = w[i];
      checks++; if (head0 !== exp_head || bus.act_data_in_vld[0] !== 1'b1) begin failures++; $display("FAIL bp_order%0d act=%h exp=%h", i, head0, exp_head); end
      tick();
      bus.src_vld = 1'b0;
    end
    checks++; if (bus.fifo_empty[0] !== 1'b1) begin failures++; $display("FAIL bp_drained act=%b exp=1", bus.fifo_empty[0]); end
    checks++; if (cnt0 !== 16'd5) begin failures++; $display("FAIL bp_cnt0 act=%0d exp=5", cnt0); end
  endtask

  task automatic test_broadcast();
    logic [31:0] r [4];
    for (int i = 0; i < 4; i++) r[i] = 32'hE200_0000 + 32'(i);
    bus.act_data_in_req = 3'b000;
    bus.src_vld = 1'b1; bus.src_row = 2'd2;
    for (int i = 0; i < 4; i++) begin
      bus.src_data = r[i];
      tick();
    end
    bus.src_row = 2'b11; bus.src_data = 32'hBCBC_0003;
    #1;
    checks++; if (bus.src_rdy !== 1'b0) begin failures++; $display("FAIL bc_blocked act=%b exp=0", bus.src_rdy); end
    tick();
    checks++; if (bus.fifo_empty !== 3'b011) begin failures++; $display("FAIL bc_no_push act=%b exp=011", bus.fifo_empty); end
    bus.act_data_in_req = 3'b100;
    tick();
    checks++; if (bus.src_rdy !== 1'b1) begin failures++; $display("FAIL bc_rdy act=%b exp=1", bus.src_rdy); end
    tick();
    bus.src_vld = 1'b0;
    checks++; if (bus.fifo_empty !== 3'b000) begin failures++; $display("FAIL bc_all_pushed act=%b exp=000", bus.fifo_empty); end
    checks++; if (head0 !== 32'hBCBC_0003 || head1 !== 32'hBCBC_0003) begin failures++; $display("FAIL bc_heads act=%h/%h exp=bcbc0003", head0, head1); end
    checks++; if (head2 !== r[2]) begin failures++; $display("FAIL bc_head2 act=%h exp=%h", head2, r[2]); end
    bus.act_data_in_req = 3'b111;
    tick();
    checks++; if (head2 !== r[3] || bus.fifo_empty !== 3'b011) begin failures++; $display("FAIL bc_step1 act=%h/%b exp=%h/011", head2, bus.fifo_empty, r[3]); end
    tick();
    checks++; if (head2 !== 32'hBCBC_0003) begin failures++; $display("FAIL bc_step2 act=%h exp=bcbc0003", head2); end
    tick();
    checks++; if (bus.fifo_empty !== 3'b111) begin failures++; $display("FAIL bc_drained act=%b exp=111", bus.fifo_empty); end
    checks++; if (cnt0 !== 16'd6 || cnt1 !== 16'd2 || cnt2 !== 16'd5) begin failures++; $display("FAIL bc_cnts act=%0d,%0d,%0d exp=6,2,5", cnt0, cnt1, cnt2); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v [4];
    for (int i = 0; i < 4; i++) v[i] = 32'hF100_0010 + 32'(i);
    bus.act_data_in_req = 3'b111;
    bus.src_vld = 1'b1; bus.src_row = 2'd1;
    for (int k = 0; k < 4; k++) begin
      bus.src_data = v[k];
      tick();
      checks++; if (head1 !== v[k] || bus.act_data_in_vld !== 3'b010) begin failures++; $display("FAIL b2b%0d act=%h/%b exp=%h/010", k, head1, bus.act_data_in_vld, v[k]); end
    end
    bus.src_vld = 1'b0;
    tick();
    checks++; if (bus.fifo_empty !== 3'b111) begin failures++; $display("FAIL b2b_empty act=%b exp=111", bus.fifo_empty); end
    checks++; if (cnt1 !== 16'd6) begin failures++; $display("FAIL b2b_cnt1 act=%0d exp=6", cnt1); end
  endtask

  task automatic test_invalid_tag();
    bus2.act_data_in_req = 2'b00;
    bus2.src_vld = 1'b1; bus2.src_row = 2'd2; bus2.src_data = 32'h0BAD_0BAD;
    #1;
    checks++; if (bus2.src_rdy !== 1'b1) begin failures++; $display("FAIL inv_rdy act=%b exp=1", bus2.src_rdy); end
    tick();
    checks++; if (bus2.err_row !== 1'b1) begin failures++; $display("FAIL inv_err act=%b exp=1", bus2.err_row); end
    checks++; if (bus2.act_data_in_vld !== 2'b00 || bus2.fifo_empty !== 2'b11) begin failures++; $display("FAIL inv_dropped act=%b/%b exp=00/11", bus2.act_data_in_vld, bus2.fifo_empty); end
    bus2.src_row = 2'd0; bus2.src_data = 32'h1234_5678;
    tick();
    bus2.src_vld = 1'b0;
    tick();
    checks++; if (bus2.err_row !== 1'b1 || bus2.act_data_in_vld !== 2'b01) begin failures++; $display("FAIL inv_sticky act=%b/%b exp=1/01", bus2.err_row, bus2.act_data_in_vld); end
  endtask

  task automatic test_flush();
    bus.act_data_in_req = 3'b000;
    bus.src_vld = 1'b1; bus.src_row = 2'd0; bus.src_data = 32'hF0F0_0000;
    tick();
    bus.src_row = 2'd1; bus.src_data = 32'hF1F1_0001;
    tick();
    bus.act_data_in_req = 3'b111; bus2.act_data_in_req = 2'b11;
    bus.src_row = 2'd2; bus.src_data = 32'hF2F2_0002;
    bus.flush = 1'b1; bus2.flush = 1'b1;
    #1;
    checks++; if (bus.src_rdy !== 1'b0) begin failures++; $display("FAIL fl_rdy act=%b exp=0", bus.src_rdy); end
    tick();
    bus.flush = 1'b0; bus2.flush = 1'b0; bus.src_vld = 1'b0;
    checks++; if (bus.fifo_empty !== 3'b111 || bus.act_data_in_vld !== 3'b000) begin failures++; $display("FAIL fl_empty act=%b/%b exp=111/000", bus.fifo_empty, bus.act_data_in_vld); end
    checks++; if (bus.xfer_cnt !== 48'h0) begin failures++; $display("FAIL fl_cnt act=%h exp=0", bus.xfer_cnt); end
    checks++; if (bus2.fifo_empty !== 2'b11 || bus2.xfer_cnt !== 32'h0) begin failures++; $display("FAIL fl_dut2 act=%b/%h exp=11/0", bus2.fifo_empty, bus2.xfer_cnt); end
    checks++; if (bus2.err_row !== 1'b1) begin failures++; $display("FAIL fl_err_kept act=%b exp=1", bus2.err_row); end
    tick();
    checks++; if (bus.fifo_empty !== 3'b111 || bus.xfer_cnt !== 48'h0) begin failures++; $display("FAIL fl_settled act=%b/%h exp=111/0", bus.fifo_empty, bus.xfer_cnt); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.src_data = '0; bus.src_row = '0; bus.src_vld = 1'b0; bus.flush = 1'b0; bus.act_data_in_req = '0;
    bus2.src_data = '0; bus2.src_row = '0; bus2.src_vld = 1'b0; bus2.flush = 1'b0; bus2.act_data_in_req = '0;
    test_reset();
    test_unicast();
    test_backpressure();
    test_broadcast();
    test_back_to_back();
    test_invalid_tag();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
